decoder_scan: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder with enable and two modes.
- DIRECT mode: registered decode of the `in` select value.
- SCAN mode: an internal index steps through outputs 0..SCAN_LAST, holding each for DWELL cycles, for display-digit and row-scanning use.
- Sits between control logic and multiplexed outputs such as 7-seg digit enables or LED matrix rows.

---
 rtl/decoder_pkg.sv | 15 +
 rtl/decoder_scan_onehot_dec.sv | 21 ++
 rtl/decoder_scan.sv | 82 ++++++++
 tb/tb_decoder_scan.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared mode encoding and a single-bit decode helper for the one-hot scan decoder.
// Combinational only; no state, no backpressure.
package decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // True when output position idx is the one selected by sel; loop it over any width.
  function automatic logic onehot_bit(input logic [31:0] sel, input logic [31:0] idx);
    return sel == idx;
  endfunction

endpackage

// File: rtl/decoder_scan_onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with enable (all zeros when disabled).
// Zero latency; no backpressure.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter  int SEL_W = 4,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [OUT_W-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < OUT_W; i++) begin
      dout[i] = en && onehot_bit(32'(sel), 32'(i));
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder: DIRECT decodes `in`, SCAN steps 0..SCAN_LAST holding each DWELL edges.
// 1-cycle latency to all outputs; no backpressure, en=0 blanks dout and freezes state.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter  int SEL_W     = 4,
  parameter  int DWELL     = 4,
  parameter  int SCAN_LAST = 2 ** SEL_W - 1,
  localparam int OUT_W     = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] in,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  output logic [OUT_W-1:0] dout,
  output logic [SEL_W-1:0] cur_sel,
  output logic             wrap
);

  localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [31:0]      LAST_U   = 32'(SCAN_LAST);

  mode_e            mode_s;
  logic [SEL_W-1:0] sel_d, sel_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             wrap_d, wrap_q;
  logic [OUT_W-1:0] dout_d, dout_q;

  assign mode_s = mode_e'(mode);

  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (en) begin
      if (mode_s == MODE_DIRECT || load) begin
        sel_d = in;
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        // Out-of-range loaded indices also fall into the wrap branch.
        if (32'(sel_q) >= LAST_U) begin
          sel_d  = '0;
          wrap_d = 1'b1;
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Decode the next index so dout and cur_sel land on the same edge.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel  (sel_d),
    .en   (en),
    .dout (dout_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      dout_q <= '0;
    end else begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      dout_q <= dout_d;
    end
  end

  assign dout    = dout_q;
  assign cur_sel = sel_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench: two decoder_scan configurations driven by shared directed and random stimulus.
module tb_decoder_scan;

  typedef struct {
    logic [15:0] dout;
    logic [3:0]  sel;
    logic        wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in;
  logic        en, mode, load;
  logic [15:0] dout_a, dout_b;
  logic [3:0]  sel_a, sel_b;
  logic        wrap_a, wrap_b;

  int total = 0;
  int bad   = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model state per configuration: [0]=defaults, [1]=SCAN_LAST 3 / DWELL 1.
  int m_idx[2];
  int m_ph[2];
  int m_dwell[2] = '{4, 1};
  int m_last[2]  = '{15, 3};

  always #5 clk = ~clk;

  decoder_scan dut_a (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en), .mode(mode), .load(load),
    .dout(dout_a), .cur_sel(sel_a), .wrap(wrap_a)
  );

  decoder_scan #(.SEL_W(4), .DWELL(1), .SCAN_LAST(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en), .mode(mode), .load(load),
    .dout(dout_b), .cur_sel(sel_b), .wrap(wrap_b)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int i, output exp_t e);
    e.wrap = 1'b0;
    if (!rst_n) begin
      m_idx[i] = 0;
      m_ph[i]  = 0;
      e.dout   = '0;
      e.sel    = '0;
      return;
    end
    if (!en) begin
      e.dout = '0;
      e.sel  = 4'(m_idx[i]);
      return;
    end
    if (!mode || load) begin
      m_idx[i] = int'(in);
      m_ph[i]  = 0;
    end else begin
      m_ph[i] = m_ph[i] + 1;
      if (m_ph[i] == m_dwell[i]) begin
        m_ph[i] = 0;
        if (m_idx[i] >= m_last[i]) begin
          m_idx[i] = 0;
          e.wrap   = 1'b1;
        end else begin
          m_idx[i] = m_idx[i] + 1;
        end
      end
    end
    e.sel  = 4'(m_idx[i]);
    e.dout = 16'(1) << m_idx[i];
  endtask

  // Expected responses are generated from the inputs seen at each rising edge.
  always @(posedge clk) begin
    exp_t ea, eb;
    model_edge(0, ea);
    model_edge(1, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_a.size() == 0) begin
      cmp("a_queue_underflow", 32'(q_a.size()), 32'd1);
    end else begin
      e = q_a.pop_front();
      cmp("a_dout", 32'(dout_a), 32'(e.dout));
      cmp("a_cur_sel", 32'(sel_a), 32'(e.sel));
      cmp("a_wrap", 32'(wrap_a), 32'(e.wrap));
    end
    if (q_b.size() == 0) begin
      cmp("b_queue_underflow", 32'(q_b.size()), 32'd1);
    end else begin
      e = q_b.pop_front();
      cmp("b_dout", 32'(dout_b), 32'(e.dout));
      cmp("b_cur_sel", 32'(sel_b), 32'(e.sel));
      cmp("b_wrap", 32'(wrap_b), 32'(e.wrap));
    end
  end

  task automatic drive(input logic r, input logic e, input logic m, input logic l,
                       input logic [3:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n = r; en = e; mode = m; load = l; in = v;
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; in = 4'd0;
    do_reset();

    // DIRECT decode of 9, then blanking with cur_sel held.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 3);

    // Free-running SCAN from reset across a full wrap of the default instance.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 70);

    // Load 12 on the edge where a step is due, then keep scanning.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 3);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd12, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 10);

    // Out-of-range load of 10 for the SCAN_LAST=3 instance.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd10, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 6);

    // Freeze mid-dwell, then resume.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 2);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 5);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 6);

    // SCAN -> DIRECT -> SCAN switching.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 6);

    // Asynchronous reset mid-cycle must clear outputs without an edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_dout_a", 32'(dout_a), 32'd0);
    cmp("async_rst_sel_a", 32'(sel_a), 32'd0);
    cmp("async_rst_wrap_a", 32'(wrap_a), 32'd0);
    cmp("async_rst_dout_b", 32'(dout_b), 32'd0);
    cmp("async_rst_sel_b", 32'(sel_b), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 9);

    // Randomized traffic, mostly enabled SCAN with occasional loads and resets.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 99) != 0);
      en    = ($urandom_range(0, 9) < 8);
      mode  = ($urandom_range(0, 9) < 7);
      load  = ($urandom_range(0, 9) == 0);
      in    = 4'($urandom_range(0, 15));
    end

    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2);
    @(negedge clk);
    cmp("a_queue_drained", 32'(q_a.size()), 32'd0);
    cmp("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
